// File: rtl/prbs_gen_if.sv
// Output word stream of the PRBS generator: valid/ready handshake carrying OUT_W bits.
// out_data[0] is the oldest generated bit.
interface prbs_gen_if #(
  parameter int OUT_W = 1
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/prbs_gen.sv
// Fibonacci-LFSR PRBS word generator; 1-cycle latency from en to out_valid, a stalled word holds data and LFSR.
// Optional bit-0 error injection under macro PRBS_ERR_INJECT_EN; default build ignores err_inj.
module prbs_gen #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b1011,
  parameter int              OUT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             err_inj,
  prbs_gen_if.master       stream,
  output logic             lockup,
  output logic [15:0]      word_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [OUT_W-1:0] word;
  logic [OUT_W-1:0] word_out;
  logic             fb;
  logic             xfer;

  // OUT_W serial steps unrolled into one cycle; bit i is the feedback of step i.
  always_comb begin
    lfsr_nxt = lfsr;
    word     = '0;
    fb       = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      fb       = ^(lfsr_nxt & TAPS);
      word[i]  = fb;
      lfsr_nxt = {lfsr_nxt[WIDTH-2:0], fb};
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // Corruption touches only the emitted word, never the LFSR state.
  always_comb begin
    word_out    = word;
    word_out[0] = word[0] ^ err_inj;
  end
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign word_out       = word;
`endif

  assign xfer = stream.out_valid && stream.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr            <= SEED;
      state           <= IDLE;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      lockup          <= 1'b0;
      word_cnt        <= 16'd0;
    end else begin
      lockup <= 1'b0;
      if (load) begin
        // A pending word is dropped uncounted; an all-zero seed would lock the LFSR.
        state            <= IDLE;
        stream.out_valid <= 1'b0;
        if (seed_in == '0) begin
          lfsr   <= SEED;
          lockup <= 1'b1;
        end else begin
          lfsr <= seed_in;
        end
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              lfsr             <= lfsr_nxt;
              stream.out_data  <= word_out;
              stream.out_valid <= 1'b1;
              state            <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (xfer) begin
              word_cnt <= word_cnt + 16'd1;
              if (en) begin
                lfsr            <= lfsr_nxt;
                stream.out_data <= word_out;
              end else begin
                stream.out_valid <= 1'b0;
                state            <= IDLE;
              end
            end
          end
          default: begin
            state            <= IDLE;
            stream.out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen: default 1-bit instance plus a 4-bit-word instance sharing stimulus.
module tb_prbs_gen;

`ifdef PRBS_ERR_INJECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  seed_in = 4'd0;
  logic        err_inj = 1'b0;
  logic        lockup_a, lockup_b;
  logic [15:0] word_cnt_a, word_cnt_b;

  int n_chk = 0;
  int n_pass = 0;

  // Hand-derived serial sequence from seed 4'b1011, taps 4'b1100.
  logic [0:14] seq = 15'b110001001101011;

  prbs_gen_if #(.OUT_W(1)) bus_a ();
  prbs_gen_if #(.OUT_W(4)) bus_b ();

  prbs_gen dut_a (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .err_inj(err_inj), .stream(bus_a), .lockup(lockup_a), .word_cnt(word_cnt_a)
  );

  prbs_gen #(.OUT_W(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .err_inj(err_inj), .stream(bus_b), .lockup(lockup_b), .word_cnt(word_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", bus_a.out_valid, 0);
    check("rst_data", bus_a.out_data, 0);
    check("rst_lockup", lockup_a, 0);
    check("rst_cnt", word_cnt_a, 0);
    check("rst_valid_b", bus_b.out_valid, 0);

    // Streaming: two full periods with an injection request on word 3.
    en = 1'b1;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      err_inj = (k == 2);
      tick();
      err_inj = 1'b0;
      check("stream_valid", bus_a.out_valid, 1);
      check("stream_data", bus_a.out_data, {31'd0, seq[k % 15] ^ (ERR_EN && k == 2)});
      check("stream_cnt", word_cnt_a, k);
      if (k == 0) check("w4_first", bus_b.out_data, 4'b0011);
      if (k == 1) check("w4_second", bus_b.out_data, 4'b0010);
    end

    // Backpressure with en toggling: word 29 must hold.
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      en = k[0];
      tick();
      check("stall_valid", bus_a.out_valid, 1);
      check("stall_data", bus_a.out_data, {31'd0, seq[14]});
      check("stall_cnt", word_cnt_a, 29);
    end
    bus_a.out_ready = 1'b1;
    en = 1'b1;
    for (int k = 30; k < 36; k++) begin
      tick();
      check("resume_data", bus_a.out_data, {31'd0, seq[k % 15]});
      check("resume_cnt", word_cnt_a, k);
    end

    // Transfer with en=0 drops to IDLE; IDLE must not advance the LFSR.
    en = 1'b0;
    tick();
    check("idle_valid", bus_a.out_valid, 0);
    check("idle_cnt", word_cnt_a, 36);
    tick();
    check("idle_hold", bus_a.out_valid, 0);
    en = 1'b1;
    tick();
    check("idle_resume_valid", bus_a.out_valid, 1);
    check("idle_resume_data", bus_a.out_data, {31'd0, seq[6]});

    // Zero-seed load during an active stream.
    load = 1'b1;
    seed_in = 4'd0;
    tick();
    load = 1'b0;
    check("load0_valid", bus_a.out_valid, 0);
    check("load0_lockup", lockup_a, 1);
    check("load0_cnt", word_cnt_a, 36);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("load0_lockup_clr", lockup_a, 0);
      check("load0_data", bus_a.out_data, {31'd0, seq[k]});
      check("load0_cnt_run", word_cnt_a, 36 + k);
    end

    // Non-zero seed load: no lockup, sequence resumes from state 0001.
    load = 1'b1;
    seed_in = 4'b0001;
    tick();
    load = 1'b0;
    check("load1_lockup", lockup_a, 0);
    check("load1_valid", bus_a.out_valid, 0);
    check("load1_cnt", word_cnt_a, 38);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("load1_data", bus_a.out_data, {31'd0, seq[6 + k]});
    end

    // Reset beats a simultaneous zero-seed load.
    reset = 1'b1;
    load = 1'b1;
    seed_in = 4'd0;
    tick();
    reset = 1'b0;
    load = 1'b0;
    check("mrst_valid", bus_a.out_valid, 0);
    check("mrst_lockup", lockup_a, 0);
    check("mrst_cnt", word_cnt_a, 0);
    check("mrst_data", bus_a.out_data, 0);
    tick();
    check("mrst_first", bus_a.out_data, {31'd0, seq[0]});
    check("mrst_first_b", bus_b.out_data, 4'b0011);

    // Counter wrap.
    repeat (65535) tick();
    check("wrap_ffff", word_cnt_a, 16'hFFFF);
    check("wrap_data", bus_a.out_data, {31'd0, seq[0]});
    tick();
    check("wrap_zero", word_cnt_a, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
